// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_ctrl_pkg
//  Description : Shared encodings for the multicycle ARM control unit: FSM
//                states, ALU operation codes, condition codes, mux-select
//                encodings, data-processing cmd codes and the condition
//                evaluation helper.
//  Ports       : (package, none)
//  Revision    : 1.0  initial release
// ============================================================================
package arm_ctrl_pkg;

  // Main FSM state encoding
  typedef logic [3:0] state_t;
  localparam state_t c_FETCH    = 4'd0;
  localparam state_t c_DECODE   = 4'd1;
  localparam state_t c_MEMADR   = 4'd2;
  localparam state_t c_MEMREAD  = 4'd3;
  localparam state_t c_MEMWB    = 4'd4;
  localparam state_t c_MEMWRITE = 4'd5;
  localparam state_t c_EXECR    = 4'd6;
  localparam state_t c_EXECI    = 4'd7;
  localparam state_t c_ALUWB    = 4'd8;
  localparam state_t c_BRANCH   = 4'd9;

  // ALUControl codes
  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_SUB = 2'b01;
  localparam logic [1:0] c_ALU_AND = 2'b10;
  localparam logic [1:0] c_ALU_ORR = 2'b11;

  // Condition codes (Instr[31:28])
  localparam logic [3:0] c_COND_EQ = 4'h0;
  localparam logic [3:0] c_COND_NE = 4'h1;
  localparam logic [3:0] c_COND_CS = 4'h2;
  localparam logic [3:0] c_COND_CC = 4'h3;
  localparam logic [3:0] c_COND_MI = 4'h4;
  localparam logic [3:0] c_COND_PL = 4'h5;
  localparam logic [3:0] c_COND_VS = 4'h6;
  localparam logic [3:0] c_COND_VC = 4'h7;
  localparam logic [3:0] c_COND_HI = 4'h8;
  localparam logic [3:0] c_COND_LS = 4'h9;
  localparam logic [3:0] c_COND_GE = 4'hA;
  localparam logic [3:0] c_COND_LT = 4'hB;
  localparam logic [3:0] c_COND_GT = 4'hC;
  localparam logic [3:0] c_COND_LE = 4'hD;
  localparam logic [3:0] c_COND_AL = 4'hE;

  // ResultSrc / ALUSrcB encodings
  localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
  localparam logic [1:0] c_RES_DATA      = 2'b01;
  localparam logic [1:0] c_RES_ALURESULT = 2'b10;
  localparam logic [1:0] c_SRCB_REG      = 2'b00;
  localparam logic [1:0] c_SRCB_IMM      = 2'b01;
  localparam logic [1:0] c_SRCB_FOUR     = 2'b10;

  // Instruction classes (Op) and data-processing cmd codes (Funct[4:1])
  localparam logic [1:0] c_OP_DP  = 2'b00;
  localparam logic [1:0] c_OP_MEM = 2'b01;
  localparam logic [1:0] c_OP_BR  = 2'b10;
  localparam logic [3:0] c_CMD_AND = 4'b0000;
  localparam logic [3:0] c_CMD_SUB = 4'b0010;
  localparam logic [3:0] c_CMD_ADD = 4'b0100;
  localparam logic [3:0] c_CMD_CMP = 4'b1010;
  localparam logic [3:0] c_CMD_ORR = 4'b1100;

  // Condition evaluation against {N,Z,C,V}; code 1111 never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      c_COND_EQ: cond_eval = z;
      c_COND_NE: cond_eval = !z;
      c_COND_CS: cond_eval = c;
      c_COND_CC: cond_eval = !c;
      c_COND_MI: cond_eval = n;
      c_COND_PL: cond_eval = !n;
      c_COND_VS: cond_eval = v;
      c_COND_VC: cond_eval = !v;
      c_COND_HI: cond_eval = c && !z;
      c_COND_LS: cond_eval = !c || z;
      c_COND_GE: cond_eval = (n == v);
      c_COND_LT: cond_eval = (n != v);
      c_COND_GT: cond_eval = !z && (n == v);
      c_COND_LE: cond_eval = z || (n != v);
      c_COND_AL: cond_eval = 1'b1;
      default:   cond_eval = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Datapath <-> control-unit bundle. The datapath (master)
//                supplies the instruction register and ALU flags; the
//                control unit (slave) returns enables and mux selects.
//  Ports       : Instr[31:0], ALUFlags[3:0] -> control
//                PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc[1:0],
//                ALUSrcA, ALUSrcB[1:0], ImmSrc[1:0], RegSrc[1:0],
//                ALUControl[1:0] -> datapath
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUControl;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );
endinterface
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
//  Module      : cond_logic
//  Description : NZCV flag register, condition evaluation and the latched
//                condition-pass bit that gates the instruction's writes.
//  Ports       : clk, reset        clock / synchronous active-high reset
//                cond_i[3:0]       instruction condition field
//                alu_flags_i[3:0]  {N,Z,C,V} from the ALU
//                flag_w_i[1:0]     [1]: update N,Z  [0]: update C,V
//                latch_i           high in DECODE; captures the condition
//                cond_ex_l_o       latched condition-pass for this instruction
//  Revision    : 1.0  initial release
// ============================================================================
module cond_logic
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       latch_i,
  output logic       cond_ex_l_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_l_q, cond_ex_l_d;
  logic       w_cond_ex;

  assign w_cond_ex = cond_eval(cond_i, flags_q);

  // Flag writes are gated by the latched pass bit, so an update in EXEC
  // cannot retroactively change whether this instruction executes.
  always_comb begin
    flags_d = flags_q;
    if (flag_w_i[1] && cond_ex_l_q) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_w_i[0] && cond_ex_l_q) flags_d[1:0] = alu_flags_i[1:0];
    cond_ex_l_d = latch_i ? w_cond_ex : cond_ex_l_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= FLAGS_RESET;
      cond_ex_l_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_ex_l_q <= cond_ex_l_d;
    end
  end

  assign cond_ex_l_o = cond_ex_l_q;

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle ARM control unit. Steps a 10-state FSM through
//                each instruction, decodes the ALU operation and produces
//                condition-gated write strobes and datapath mux selects.
//  Ports       : clk    system clock
//                reset  synchronous active-high reset
//                bus    multicycle_control_if.slave (Instr/ALUFlags in,
//                       enables and selects out)
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.slave   bus
);

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_unused;

  assign w_cond   = bus.Instr[31:28];
  assign w_op     = bus.Instr[27:26];
  assign w_funct  = bus.Instr[25:20];
  assign w_rd     = bus.Instr[15:12];
  assign w_unused = ^{bus.Instr[19:16], bus.Instr[11:0]};

  state_t state_q, state_d;

  always_comb begin
    state_d = c_FETCH;
    case (state_q)
      c_FETCH:  state_d = c_DECODE;
      c_DECODE: begin
        case (w_op)
          c_OP_MEM: state_d = c_MEMADR;
          c_OP_DP:  state_d = w_funct[5] ? c_EXECI : c_EXECR;
          c_OP_BR:  state_d = c_BRANCH;
          default:  state_d = c_FETCH;   // Op=11 behaves as a NOP
        endcase
      end
      c_MEMADR:         state_d = w_funct[0] ? c_MEMREAD : c_MEMWRITE;
      c_MEMREAD:        state_d = c_MEMWB;
      c_EXECR, c_EXECI: state_d = c_ALUWB;
      default:          state_d = c_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= c_FETCH;
    else       state_q <= state_d;
  end

  // ALU decode; the cmd-level result is computed unconditionally because
  // ALUWB still needs NoWrite after ALUOp has dropped.
  logic [1:0] w_dec_ctl, w_dec_flag_w, w_flag_w;
  logic       w_no_write, w_s;
  assign w_s = w_funct[0];

  always_comb begin
    w_dec_ctl    = c_ALU_ADD;
    w_dec_flag_w = 2'b00;
    w_no_write   = 1'b0;
    case (w_funct[4:1])
      c_CMD_ADD: begin w_dec_ctl = c_ALU_ADD; w_dec_flag_w = {w_s, w_s};  end
      c_CMD_SUB: begin w_dec_ctl = c_ALU_SUB; w_dec_flag_w = {w_s, w_s};  end
      c_CMD_AND: begin w_dec_ctl = c_ALU_AND; w_dec_flag_w = {w_s, 1'b0}; end
      c_CMD_ORR: begin w_dec_ctl = c_ALU_ORR; w_dec_flag_w = {w_s, 1'b0}; end
      c_CMD_CMP: begin w_dec_ctl = c_ALU_SUB; w_dec_flag_w = 2'b11; w_no_write = 1'b1; end
      default:   w_no_write = 1'b1;
    endcase
  end

  // Per-state raw controls
  logic       w_next_pc, w_reg_w, w_mem_w, w_branch, w_alu_op, w_adr_src, w_src_a;
  logic [1:0] w_res_src, w_src_b;

  always_comb begin
    w_next_pc = 1'b0;
    w_reg_w   = 1'b0;
    w_mem_w   = 1'b0;
    w_branch  = 1'b0;
    w_alu_op  = 1'b0;
    w_adr_src = 1'b0;
    w_src_a   = 1'b0;
    w_res_src = c_RES_ALUOUT;
    w_src_b   = c_SRCB_REG;
    case (state_q)
      c_FETCH: begin
        w_next_pc = 1'b1; w_src_a = 1'b1; w_src_b = c_SRCB_FOUR; w_res_src = c_RES_ALURESULT;
      end
      c_DECODE: begin
        w_src_a = 1'b1; w_src_b = c_SRCB_FOUR; w_res_src = c_RES_ALURESULT;
      end
      c_MEMADR:   w_src_b = c_SRCB_IMM;
      c_MEMREAD:  w_adr_src = 1'b1;
      c_MEMWB:    begin w_res_src = c_RES_DATA; w_reg_w = 1'b1; end
      c_MEMWRITE: begin w_adr_src = 1'b1; w_mem_w = 1'b1; end
      c_EXECR:    w_alu_op = 1'b1;
      c_EXECI:    begin w_src_b = c_SRCB_IMM; w_alu_op = 1'b1; end
      c_ALUWB:    w_reg_w = !w_no_write;
      c_BRANCH: begin
        w_src_b = c_SRCB_IMM; w_res_src = c_RES_ALURESULT; w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_flag_w = w_alu_op ? w_dec_flag_w : 2'b00;

  logic w_cond_ex_l;

  cond_logic #(
    .FLAGS_RESET (FLAGS_RESET)
  ) u_cond_logic (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (w_cond),
    .alu_flags_i (bus.ALUFlags),
    .flag_w_i    (w_flag_w),
    .latch_i     (state_q == c_DECODE),
    .cond_ex_l_o (w_cond_ex_l)
  );

  // Writes to R15 through the register path are PC writes.
  logic w_pcs;
  assign w_pcs = (w_reg_w && (w_rd == 4'hF)) || w_branch;

  assign bus.PCWrite    = !reset && (w_next_pc || (w_pcs && w_cond_ex_l));
  assign bus.RegWrite   = !reset && w_reg_w && w_cond_ex_l;
  assign bus.MemWrite   = !reset && w_mem_w && w_cond_ex_l;
  assign bus.IRWrite    = !reset && (state_q == c_FETCH);
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ResultSrc  = w_res_src;
  assign bus.ALUSrcA    = w_src_a;
  assign bus.ALUSrcB    = w_src_b;
  assign bus.ImmSrc     = w_op;
  assign bus.RegSrc     = {w_op == c_OP_MEM, w_op == c_OP_BR};
  assign bus.ALUControl = w_alu_op ? w_dec_ctl : c_ALU_ADD;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control: a directed
//                vector table, a mid-instruction reset sequence, and random
//                instructions checked against an instruction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus_if();

  multicycle_control #(
    .FLAGS_RESET (4'b0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic logic [3:0] strobes();
    return {bus_if.IRWrite, bus_if.PCWrite, bus_if.MemWrite, bus_if.RegWrite};
  endfunction

  // ---------------- directed vector table ----------------
  // Masks: bit i refers to cycle i of the instruction (cycle 0 = FETCH).
  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  af;
    logic [2:0]  len;
    logic [4:0]  pcw;
    logic [4:0]  regw;
    logic [4:0]  memw;
    logic [1:0]  ctl2;
    logic [1:0]  rsrc_last;
    logic        adr_last;
  } vec_t;

  vec_t tbl [18];

  task automatic run_vec(input vec_t v, input int idx);
    bus_if.Instr    = v.instr;
    bus_if.ALUFlags = v.af;
    for (int c = 0; c < int'(v.len); c++) begin
      @(negedge clk);
      chk($sformatf("vec%0d.cyc%0d.strobes", idx, c), 32'(strobes()),
          32'({c == 0, v.pcw[c], v.memw[c], v.regw[c]}));
      if (c == 2)
        chk($sformatf("vec%0d.aluctl", idx), 32'(bus_if.ALUControl), 32'(v.ctl2));
      if (c == int'(v.len) - 1)
        chk($sformatf("vec%0d.last_rsrc_adr", idx),
            32'({bus_if.ResultSrc, bus_if.AdrSrc}), 32'({v.rsrc_last, v.adr_last}));
      @(posedge clk); #1;
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef struct packed {
    logic       irw, pcw, memw, regw, adr;
    logic [1:0] rsrc;
    logic       srca;
    logic [1:0] srcb, ctl, imm, regsrc;
  } obs_t;

  obs_t       m_seq [5];
  int         m_len;
  logic       m_ok;
  logic [3:0] m_fmask;
  logic [3:0] m_flags;

  function automatic obs_t sample();
    obs_t o;
    o.irw = bus_if.IRWrite;   o.pcw = bus_if.PCWrite;   o.memw = bus_if.MemWrite;
    o.regw = bus_if.RegWrite; o.adr = bus_if.AdrSrc;    o.rsrc = bus_if.ResultSrc;
    o.srca = bus_if.ALUSrcA;  o.srcb = bus_if.ALUSrcB;  o.ctl = bus_if.ALUControl;
    o.imm = bus_if.ImmSrc;    o.regsrc = bus_if.RegSrc;
    return o;
  endfunction

  // Even codes test a base predicate, odd codes its inverse (so 1111 = never).
  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return cc[0] ? ~base : base;
  endfunction

  task automatic build(input logic [31:0] ins);
    logic [1:0] op, ctl;
    logic       writes, s, wr_pc;
    obs_t       b;
    op = ins[27:26];
    s  = ins[20];
    b  = '0;
    b.imm    = op;
    b.regsrc = {op == 2'b01, op == 2'b10};
    m_ok     = cond_true(ins[31:28], m_flags);
    wr_pc    = m_ok && (ins[15:12] == 4'hF);
    m_fmask  = 4'h0;
    m_seq[0] = b; m_seq[0].irw = 1; m_seq[0].pcw = 1; m_seq[0].rsrc = 2; m_seq[0].srca = 1; m_seq[0].srcb = 2;
    m_seq[1] = b; m_seq[1].rsrc = 2; m_seq[1].srca = 1; m_seq[1].srcb = 2;
    case (op)
      2'b00: begin
        writes = 1'b1;
        case (ins[24:21])
          4'd4:  begin ctl = 2'd0; if (s) m_fmask = 4'hF; end
          4'd2:  begin ctl = 2'd1; if (s) m_fmask = 4'hF; end
          4'd0:  begin ctl = 2'd2; if (s) m_fmask = 4'hC; end
          4'd12: begin ctl = 2'd3; if (s) m_fmask = 4'hC; end
          4'd10: begin ctl = 2'd1; m_fmask = 4'hF; writes = 1'b0; end
          default: begin ctl = 2'd0; writes = 1'b0; end
        endcase
        m_len = 4;
        m_seq[2] = b; m_seq[2].srcb = ins[25] ? 2'd1 : 2'd0; m_seq[2].ctl = ctl;
        m_seq[3] = b; m_seq[3].regw = m_ok && writes; m_seq[3].pcw = wr_pc && writes;
      end
      2'b01: begin
        m_seq[2] = b; m_seq[2].srcb = 2'd1;
        m_seq[3] = b; m_seq[3].adr = 1;
        if (s) begin
          m_len = 5;
          m_seq[4] = b; m_seq[4].rsrc = 2'd1; m_seq[4].regw = m_ok; m_seq[4].pcw = wr_pc;
        end else begin
          m_len = 4;
          m_seq[3].memw = m_ok;
        end
      end
      2'b10: begin
        m_len = 3;
        m_seq[2] = b; m_seq[2].srcb = 2'd1; m_seq[2].rsrc = 2'd2; m_seq[2].pcw = m_ok;
      end
      default: m_len = 2;
    endcase
    if (!m_ok) m_fmask = 4'h0;
  endtask

  logic [3:0] cmd_pool [5] = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10};

  function automatic logic [31:0] gen();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) r[31:28] = 4'hE;
    if (r[27:26] == 2'b00 && $urandom_range(0, 3) != 0) r[24:21] = cmd_pool[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) r[15:12] = 4'hF;
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    logic [3:0]  a;
    //              instr         af     len   pcw       regw      memw      ctl2   rsrc  adr
    tbl[0]  = '{32'hE0812003, 4'h0, 3'd4, 5'b00001, 5'b01000, 5'b00000, 2'b00, 2'b00, 1'b0}; // ADD
    tbl[1]  = '{32'hE3530005, 4'h4, 3'd4, 5'b00001, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0}; // CMP -> Z
    tbl[2]  = '{32'h0A000002, 4'h0, 3'd3, 5'b00101, 5'b00000, 5'b00000, 2'b00, 2'b10, 1'b0}; // BEQ taken
    tbl[3]  = '{32'h10912003, 4'hB, 3'd4, 5'b00001, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0}; // ADDSNE skip
    tbl[4]  = '{32'h1A000002, 4'h0, 3'd3, 5'b00001, 5'b00000, 5'b00000, 2'b00, 2'b10, 1'b0}; // BNE not taken
    tbl[5]  = '{32'hE0912003, 4'h0, 3'd4, 5'b00001, 5'b01000, 5'b00000, 2'b00, 2'b00, 1'b0}; // ADDS -> 0000
    tbl[6]  = '{32'h0A000002, 4'h0, 3'd3, 5'b00001, 5'b00000, 5'b00000, 2'b00, 2'b10, 1'b0}; // BEQ not taken
    tbl[7]  = '{32'h10912003, 4'h4, 3'd4, 5'b00001, 5'b01000, 5'b00000, 2'b00, 2'b00, 1'b0}; // ADDSNE exec
    tbl[8]  = '{32'h0A000002, 4'h0, 3'd3, 5'b00101, 5'b00000, 5'b00000, 2'b00, 2'b10, 1'b0}; // BEQ taken
    tbl[9]  = '{32'hE5912000, 4'h0, 3'd5, 5'b00001, 5'b10000, 5'b00000, 2'b00, 2'b01, 1'b0}; // LDR
    tbl[10] = '{32'hE5812000, 4'h0, 3'd4, 5'b00001, 5'b00000, 5'b01000, 2'b00, 2'b00, 1'b1}; // STR
    tbl[11] = '{32'hE081F003, 4'h0, 3'd4, 5'b01001, 5'b01000, 5'b00000, 2'b00, 2'b00, 1'b0}; // ADD PC
    tbl[12] = '{32'hF0812003, 4'h0, 3'd4, 5'b00001, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0}; // cond NV
    tbl[13] = '{32'hEC000000, 4'h0, 3'd2, 5'b00001, 5'b00000, 5'b00000, 2'b00, 2'b10, 1'b0}; // Op=11 NOP
    tbl[14] = '{32'hE0012003, 4'h0, 3'd4, 5'b00001, 5'b01000, 5'b00000, 2'b10, 2'b00, 1'b0}; // AND
    tbl[15] = '{32'hE1812003, 4'h0, 3'd4, 5'b00001, 5'b01000, 5'b00000, 2'b11, 2'b00, 1'b0}; // ORR
    tbl[16] = '{32'hE0412003, 4'h0, 3'd4, 5'b00001, 5'b01000, 5'b00000, 2'b01, 2'b00, 1'b0}; // SUB
    tbl[17] = '{32'hE1012003, 4'h0, 3'd4, 5'b00001, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0}; // TST (no write)

    // Reset held for two cycles: no strobes, even once the FSM sits in FETCH.
    reset = 1'b1;
    bus_if.Instr    = 32'hE0812003;
    bus_if.ALUFlags = 4'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("reset.cyc%0d.strobes", c), 32'(strobes()), 32'h0);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

    // Flags are Z=1 here. Start a load and reset it in MEMREAD.
    bus_if.Instr = 32'hE5912000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("ldr_abort.cyc%0d.strobes", c), 32'(strobes()), 32'({c == 0, c == 0, 2'b00}));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("ldr_abort.reset.strobes", 32'(strobes()), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    // FETCH on the first cycle, and Z back to 0 so BEQ falls through.
    run_vec(tbl[6], 100);

    // Random instructions against the model, with occasional resets.
    m_flags = 4'h0;
    for (int k = 0; k < 300; k++) begin
      ins = gen();
      build(ins);
      bus_if.Instr = ins;
      for (int c = 0; c < m_len; c++) begin
        a = 4'($urandom);
        bus_if.ALUFlags = a;
        if ($urandom_range(0, 79) == 0) begin
          reset = 1'b1;
          @(negedge clk);
          chk($sformatf("rnd%0d.cyc%0d.reset_strobes", k, c), 32'(strobes()), 32'h0);
          @(posedge clk); #1;
          reset = 1'b0;
          m_flags = 4'h0;
          break;
        end
        @(negedge clk);
        chk($sformatf("rnd%0d.cyc%0d.outputs", k, c), 32'(sample()), 32'(m_seq[c]));
        @(posedge clk); #1;
        if (c == 2) m_flags = (m_flags & ~m_fmask) | (a & m_fmask);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the multicycle ARM datapath, directly upstream of the ALU.
- Decodes the instruction held in the instruction register and steps a 10-state main FSM through each instruction, one state per clock.
- Drives the ALU operation code and the datapath mux selects.
- Registers the ALU's NZCV flags and gates every architectural write strobe by the instruction's condition field.

Parameters:
FLAGS_RESET, 4'b0000, NZCV value loaded into the flag register on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Instr  input  32  instruction register contents; Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]
ALUFlags  input  4  {N,Z,C,V} from ALU, same cycle as the Execute state
PCWrite  output  1  PC register enable
MemWrite  output  1  data memory write enable
RegWrite  output  1  register file write enable
IRWrite  output  1  instruction register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
ResultSrc  output  2  result mux select: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  1  ALU A select: 0=register A, 1=PC
ALUSrcB  output  2  ALU B select: 00=register WD, 01=ExtImm, 10=constant 4
ImmSrc  output  2  extend control, equals Op
RegSrc  output  2  register-read address selects: bit0=(Op==10), bit1=(Op==01)
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset:
  - Registered effects: state<=FETCH, Flags<=FLAGS_RESET, CondExL<=0.
  - While reset=1, PCWrite/MemWrite/RegWrite/IRWrite are forced 0.
  - Reset mid-instruction abandons the instruction; FETCH occurs on the first cycle after reset deasserts.
- Every state lasts exactly 1 cycle. Outputs are combinational from state, decoded fields, CondExL and Flags.
- FSM transitions:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00&Funct[5]=0->EXECR; Op=00&Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->FETCH (undefined, treated as NOP).
  - MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH.
  - MEMWRITE->FETCH.
  - EXECR/EXECI->ALUWB->FETCH.
  - BRANCH->FETCH.
- Latency in cycles: branch 3; store 4; data-processing 4; load 5.
- Per-state raw controls (unlisted controls are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemW=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1 unless NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, by cmd=Funct[4:1]:
    - 0100: ADD, ALUControl=00.
    - 0010: SUB, ALUControl=01.
    - 0000: AND, ALUControl=10.
    - 1100: ORR, ALUControl=11.
    - 1010: CMP, ALUControl=01, NoWrite=1, FlagW=11 regardless of S.
    - Any other cmd: ALUControl=00, FlagW=00, NoWrite=1.
  - For ADD/SUB/AND/ORR: FlagW[1]=S (Funct[0]); FlagW[0]=S only for ADD/SUB.
- Condition evaluation:
  - CondEx is computed from Cond and registered Flags.
  - Codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 -> 0.
  - CondExL latches CondEx at the end of DECODE and is held to FETCH.
- Strobes:
  - PCS = (RegW & Rd==15) | Branch.
  - PCWrite = NextPC | (PCS & CondExL).
  - RegWrite = RegW & CondExL.
  - MemWrite = MemW & CondExL.
- Flag register:
  - Flags[3:2] <= ALUFlags[3:2] at the end of EXECR/EXECI iff FlagW[1] & CondExL.
  - Flags[1:0] <= ALUFlags[1:0] iff FlagW[0] & CondExL.
  - Flags change at no other time. A flag update never alters the current instruction's CondExL.

Decomposition:
- Package arm_ctrl_pkg holds:
  - state enum (FETCH..BRANCH);
  - ALUControl constants;
  - cond-code constants;
  - ResultSrc/ALUSrcB encodings;
  - cmd encodings.
- One sub-module, cond_logic, holds Flags, the CondEx decode, CondExL, and the flag-write enables.

Test Plan:
- Reset held 2 cycles, then released with Instr=E0812003 (ADD R2,R1,R3, AL) -> state sequence FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; ALUControl=00 in EXECR; no strobes during reset.
- Instr=E3530005 (CMP R3,#5) with ALUFlags=4'b0100 in EXECI -> Flags=0100; RegWrite never asserted; ALUControl=01.
- Flags Z=1, Instr=0A000002 (BEQ) -> PCWrite=1 in BRANCH. Flags Z=0, same instruction -> PCWrite=0 in BRANCH and the FSM returns to FETCH.
- Instr=E5912000 (LDR) -> 5-cycle sequence ending MEMWB with ResultSrc=01, RegWrite=1. Instr=E5812000 (STR) -> MEMWRITE with MemWrite=1, AdrSrc=1.
- Instr=10912003 (ADDSNE) with Z=1 -> no RegWrite, Flags unchanged. With Z=0 and ALUFlags=4'b0100 -> Flags<=0100, RegWrite=1 in ALUWB (CondExL held).
- reset asserted in MEMREAD -> strobes 0 immediately, FETCH on the first post-reset cycle, Flags=FLAGS_RESET.
